// File: rtl/bram_burst_pkg.sv
// Shared types and constants for the bram_burst block.
package bram_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned OCC_WIDTH  = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_burst_skid.sv
// Two-entry read-data FIFO; head entry drives the output directly.
module bram_burst_skid
    import bram_burst_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic [WIDTH-1:0]     dout,
    output logic                 valid,
    output logic [OCC_WIDTH-1:0] count
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == '0) entry0 <= din;
                    else             entry1 <= din;
                    count <= count + OCC_WIDTH'(1);
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - OCC_WIDTH'(1);
                end
                2'b11: begin
                    // Occupancy unchanged; new data lands behind whatever remains.
                    if (count == OCC_WIDTH'(1)) begin
                        entry0 <= din;
                    end else begin
                        entry0 <= entry1;
                        entry1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = entry0;
    assign valid = (count != '0);

endmodule

// File: rtl/bram_true2p_2clk.sv
// Dual-port block RAM, read-first, one clock per port. Port B is read-only here.
module bram_true2p_2clk #(
    parameter int unsigned data_width = 8,
    parameter int unsigned addr_width = 12
) (
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [addr_width-1:0] addra,
    input  logic [data_width-1:0] dia,
    output logic [data_width-1:0] doa,
    input  logic                  clkb,
    input  logic                  enb,
    input  logic [addr_width-1:0] addrb,
    output logic [data_width-1:0] dob
);

    logic [data_width-1:0] mem [2**addr_width];

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) mem[addra] <= dia;
            doa <= mem[addra];
        end
    end

    always_ff @(posedge clkb) begin
        if (enb) dob <= mem[addrb];
    end

endmodule

// File: rtl/bram_burst.sv
// Burst-addressed BRAM: command FSM, per-lane RAMs and a credit-limited read skid FIFO.
module bram_burst
    import bram_burst_pkg::*;
#(
    parameter int unsigned BYTES      = 4,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [8*BYTES-1:0]    wdata,
    input  logic [BYTES-1:0]      wstrb,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [8*BYTES-1:0]    rdata,
    output logic                  rlast,
    output logic                  busy
);

    localparam int unsigned DW = 8 * BYTES;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  beats;
    logic                  inflight;
    logic                  inflight_last;
    logic [OCC_WIDTH-1:0]  occ;
    logic [DW-1:0]         ram_q;
    logic [DW-1:0]         unused_dob;

    logic cmd_hs;
    logic wr_hs;
    logic pop;
    logic rd_issue;
    logic ram_en;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign wr_hs  = wvalid & wready;
    assign pop    = rvalid & rready;
    assign ram_en = wr_hs | rd_issue;

    // Issue only if the FIFO can still absorb everything already committed.
    assign rd_issue = (state == ST_READ) &&
                      ((3'(occ) + 3'(inflight)) <= (3'(FIFO_DEPTH - 1) + 3'(pop)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            addr          <= '0;
            beats         <= '0;
            cmd_ready     <= 1'b0;
            wready        <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rd_issue;
            inflight_last <= rd_issue && (beats == '0);
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    wready    <= 1'b0;
                    if (cmd_hs) begin
                        addr      <= cmd_addr;
                        beats     <= cmd_len;
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            state  <= ST_WRITE;
                            wready <= 1'b1;
                        end else begin
                            state  <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_hs) begin
                        addr  <= addr + ADDR_WIDTH'(1);
                        beats <= beats - LEN_WIDTH'(1);
                        if (beats == '0) begin
                            state     <= ST_IDLE;
                            wready    <= 1'b0;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (rd_issue) begin
                        addr  <= addr + ADDR_WIDTH'(1);
                        beats <= beats - LEN_WIDTH'(1);
                        if (beats == '0) begin
                            state     <= ST_IDLE;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b0;
                    wready    <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        bram_true2p_2clk #(
            .data_width(8),
            .addr_width(ADDR_WIDTH)
        ) u_lane (
            .clka (clk),
            .ena  (ram_en),
            .wea  (wr_hs & wstrb[i]),
            .addra(addr),
            .dia  (wdata[8*i +: 8]),
            .doa  (ram_q[8*i +: 8]),
            .clkb (clk),
            .enb  (1'b0),
            .addrb({ADDR_WIDTH{1'b0}}),
            .dob  (unused_dob[8*i +: 8])
        );
    end

    bram_burst_skid #(
        .WIDTH(DW + 1)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .din  ({inflight_last, ram_q}),
        .pop  (pop),
        .dout ({rlast, rdata}),
        .valid(rvalid),
        .count(occ)
    );

    assign busy = (state != ST_IDLE) || inflight || rvalid;

endmodule

// File: tb/tb_bram_burst.sv
// Directed and randomized bench for bram_burst against a word-array memory model.
module tb_bram_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        rlast;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_m [int];

    bram_burst dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rvalid   (rvalid),
        .rready   (rready),
        .rdata    (rdata),
        .rlast    (rlast),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        n_fail++;
        $error("FAIL %s: timed out waiting for DUT", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_word(input int a);
        if (mem_m.exists(a)) return mem_m[a];
        return 'x;
    endfunction

    // Returns once the handshake edge has passed.
    task automatic send_cmd(input logic wr, input logic [11:0] a, input logic [3:0] len);
        bit hs;
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_len   = len;
        do begin
            hs = cmd_ready;
            step();
            n++;
        end while (!hs && n < 50);
        if (!hs) timeout("cmd_handshake");
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [3:0] len,
                            input bit rnd, input logic [31:0] base, input logic [3:0] strb);
        int k = 0;
        int n = 0;
        bit hs;
        logic [31:0] w;
        send_cmd(1'b1, a, len);
        while (k <= int'(len) && n < 200) begin
            wvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            wdata  = rnd ? $urandom : base * 32'(k + 1);
            wstrb  = rnd ? 4'($urandom_range(0, 15)) : strb;
            hs     = wvalid && wready;
            step();
            n++;
            if (hs) begin
                w = model_word(int'((a + 12'(k)) & 12'hFFF));
                for (int i = 0; i < 4; i++) if (wstrb[i]) w[8*i +: 8] = wdata[8*i +: 8];
                mem_m[int'((a + 12'(k)) & 12'hFFF)] = w;
                k++;
            end
        end
        wvalid = 1'b0;
        if (k <= int'(len)) timeout("write_beats");
    endtask

    task automatic do_read(input logic [11:0] a, input logic [3:0] len, input bit rnd,
                           input bit check_rate);
        int k = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        send_cmd(1'b0, a, len);
        while (k <= int'(len) && cyc < 300) begin
            rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check("occupancy_le_2", 64'(dut.u_skid.count <= 2'd2), 64'd1);
            if (rvalid && first < 0) begin
                first = cyc;
                check("read_latency", 64'(cyc), 64'd2);
            end
            if (rvalid && rready) begin
                check("rdata", 64'(rdata), 64'(model_word(int'((a + 12'(k)) & 12'hFFF))));
                check("rlast", 64'(rlast), 64'(k == int'(len)));
                last = cyc;
                k++;
            end
            step();
            cyc++;
        end
        rready = 1'b0;
        if (k <= int'(len)) timeout("read_beats");
        if (check_rate) check("full_rate_span", 64'(last - first), 64'(len));
        check("busy_after_read", 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rlast", 64'(rlast), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        step();
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        // Basic burst write then read back.
        do_write(12'h010, 4'd3, 1'b0, 32'h11111111, 4'hF);
        do_read(12'h010, 4'd3, 1'b0, 1'b1);

        // Partial strobe over a zeroed word.
        do_write(12'h020, 4'd0, 1'b0, 32'h0, 4'hF);
        do_write(12'h020, 4'd0, 1'b0, 32'hAABBCCDD, 4'b0101);
        check("strobe_model", 64'(mem_m[32'h20]), 64'h00BB00DD);
        do_read(12'h020, 4'd0, 1'b0, 1'b0);

        // Wrap across the top of the address space.
        do_write(12'hFFE, 4'd3, 1'b0, 32'h01020304, 4'hF);
        do_read(12'hFFE, 4'd3, 1'b0, 1'b1);
        do_read(12'h000, 4'd1, 1'b1, 1'b0);

        // Random data/strobes, then backpressured and full-rate reads.
        do_write(12'h100, 4'd15, 1'b0, 32'h5A5A0001, 4'hF);
        do_write(12'h100, 4'd15, 1'b1, 32'h0, 4'h0);
        do_read(12'h100, 4'd15, 1'b1, 1'b0);
        do_read(12'h100, 4'd15, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            do_write(12'h100 + 12'(r * 5), 4'($urandom_range(0, 6)), 1'b1, 32'h0, 4'h0);
            do_read(12'h100, 4'd15, 1'b1, 1'b0);
        end

        // Reset during beat 2 of an 8-beat read.
        send_cmd(1'b0, 12'h100, 4'd7);
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        if (!rvalid) timeout("reset_read_first_beat");
        step();
        rst = 1'b1;
        #1;
        check("midread_rst_rvalid", 64'(rvalid), 64'd0);
        check("midread_rst_busy", 64'(busy), 64'd0);
        check("midread_rst_wready", 64'(wready), 64'd0);
        rready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("midread_cmd_ready", 64'(cmd_ready), 64'd1);
        check("midread_rvalid_after", 64'(rvalid), 64'd0);

        // Reset part-way through an 8-beat write; accepted beats persist.
        send_cmd(1'b1, 12'h200, 4'd7);
        for (int k = 0; k < 3; k++) begin
            wvalid = 1'b1;
            wdata  = $urandom;
            wstrb  = 4'hF;
            if (!wready) timeout("reset_write_wready");
            step();
            mem_m[32'h200 + k] = wdata;
        end
        rst = 1'b1;
        wvalid = 1'b0;
        #1;
        check("midwrite_rst_wready", 64'(wready), 64'd0);
        check("midwrite_rst_busy", 64'(busy), 64'd0);
        step();
        rst = 1'b0;
        step();
        check("midwrite_cmd_ready", 64'(cmd_ready), 64'd1);
        do_read(12'h200, 4'd2, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_burst.md
# bram_burst

Single-clock, byte-lane-parametrised BRAM with a burst command port, per-byte write strobes and a back-pressured read-data stream. Each byte lane is one existing `bram_true2p_2clk` instance; this block adds the burst address/beat counters, the command state machine and a 2-entry read skid FIFO. It connects DMA-style masters, such as the video fetcher or the SD copier, to on-chip RAM without per-word address handshakes.

## Interface
- `BYTES`, 4: byte lanes; data width is 8·BYTES.
- `ADDR_WIDTH`, 12: word-address width; depth is 2^ADDR_WIDTH words.
- `LEN_WIDTH`, 4: burst-length field width; a burst carries at most 2^LEN_WIDTH beats.
- `clk` in 1: single clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both valid and ready are high.
- `cmd_write` in 1: 1 = write burst, 0 = read burst.
- `cmd_addr` in ADDR_WIDTH: first word address.
- `cmd_len` in LEN_WIDTH: beats − 1.
- `wvalid` in 1: write beat offered.
- `wready` out 1: write beat accepted when both valid and ready are high.
- `wdata` in 8·BYTES: write data; lane i is bits [8i+7:8i].
- `wstrb` in BYTES: per-lane write enable.
- `rvalid` out 1: read beat available.
- `rready` in 1: read beat consumed when both valid and ready are high.
- `rdata` out 8·BYTES: read data.
- `rlast` out 1: marks the final beat of a read burst.
- `busy` out 1: high when the block is not in IDLE, or when any read is in flight or queued.

## Operation
- States:
  - IDLE: `cmd_ready` = 1. A handshake loads the address counter with `cmd_addr` and the beat counter with `cmd_len`, then moves to WRITE or READ.
  - WRITE: `wready` = 1. Each write handshake writes the lanes selected by `wstrb` at the counter address, then increments the address. When the beat counter reaches 0, the block returns to IDLE.
  - READ: issues one BRAM read per cycle while credit allows. Each issue increments the address and decrements the beat counter. The issue with counter = 0 is tagged last, and after it the block returns to IDLE.
- Credit rule: a read may issue only when FIFO occupancy + in-flight reads − (pop this cycle) ≤ 1. With this rule the FIFO never overflows and never drops data.
- Address arithmetic is modulo 2^ADDR_WIDTH: a burst crossing the top word wraps to address 0.
- `wstrb` = 0 is a valid beat. It consumes a beat and increments the address without changing memory.
- Reads drain independently of the state machine. A new command may be accepted while earlier read data is still queued.
- Read-after-write: a read issued on any cycle after a write beat returns the new data. A write beat issued after a read returns the old data to that read.
- Memory contents are not reset.
- Reset values: `cmd_ready` = 0 while `rst` is high and 1 after release. `wready`, `rvalid`, `rlast` and `busy` are 0. `rdata` is 0.
- Reset mid-burst: the burst is abandoned and the FIFO and in-flight read are flushed. Write beats already accepted remain in memory.

## Timing
- Command handshake at edge E0, so the state changes at E0.
- Write: the first beat can be accepted at E1. Sustained rate is 1 beat/cycle.
- Read: the BRAM captures the address at E1, the FIFO captures the data at E2, and `rvalid` is high after E2. Latency is therefore 2 cycles from the command handshake.
- Read throughput is 1 beat/cycle while `rready` stays high.
- `rready` low: at most 2 beats are buffered and issuing stalls. Once `rready` returns high, data continues without a bubble.
- Back-to-back commands: the next command can be accepted the cycle after the last write beat or last read issue.

## Structure
- Shared package holds the state enum (IDLE/WRITE/READ) and the FIFO depth constant (2).
- Storage uses a generate loop of BYTES `bram_true2p_2clk` instances, with port A only, single clock, `data_width` = 8 and port B tied off.
- A single sub-module `bram_burst_skid` is the 2-entry FIFO carrying {rdata, rlast}, with a registered occupancy count.

## Test plan
- Write burst, addr 0x010, len 3, data 0x11111111..0x44444444, all strobes; then read the same burst → data returned in order, `rlast` on the 4th beat, first `rvalid` 2 cycles after the read handshake.
- Strobe test: write 0xAABBCCDD with `wstrb` = 0101 over a word holding 0x00000000 → reads back 0x00BB00DD.
- Wrap test: burst at addr 0xFFE, len 3 (ADDR_WIDTH = 12) → beats go to 0xFFE, 0xFFF, 0x000, 0x001.
- Backpressure test: 16-beat read with `rready` toggling pseudo-randomly → all 16 words delivered in order, no duplicates or drops, occupancy never exceeds 2.
- Full-rate test: 16-beat read with `rready` held high → 16 consecutive `rvalid` cycles.
- Reset test: assert `rst` during beat 2 of an 8-beat read → `rvalid`, `busy` and `wready` go 0 immediately and `cmd_ready` is 1 after release. In a separate 8-beat write, the beats accepted before reset remain readable after reset.
